// File: rtl/median_filter_5x5_window.sv
// median_filter_5x5_window: streams raster pixels through four line buffers and
// emits every fully-interior 5x5 neighbourhood with a one-cycle strobe.
module median_filter_5x5_window #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_i,
  input  logic [7:0] pixel_i,
  output logic [7:0] S1,
  output logic [7:0] S2,
  output logic [7:0] S3,
  output logic [7:0] S4,
  output logic [7:0] S5,
  output logic [7:0] S6,
  output logic [7:0] S7,
  output logic [7:0] S8,
  output logic [7:0] S9,
  output logic [7:0] S10,
  output logic [7:0] S11,
  output logic [7:0] S12,
  output logic [7:0] S13,
  output logic [7:0] S14,
  output logic [7:0] S15,
  output logic [7:0] S16,
  output logic [7:0] S17,
  output logic [7:0] S18,
  output logic [7:0] S19,
  output logic [7:0] S20,
  output logic [7:0] S21,
  output logic [7:0] S22,
  output logic [7:0] S23,
  output logic [7:0] S24,
  output logic [7:0] S25,
  output logic       done_o,
  output logic       frame_done_o
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [0:0] state;
  logic [7:0] lb [4][IMG_WIDTH];
  logic [7:0] win [5][5];
  logic [7:0] nxt [5][5];
  logic [7:0] s [25];
  logic last_col, last_row, valid;
  always_comb begin
    state = row >= RW'(4) ? STREAM : FILL;
    last_col = col == CW'(IMG_WIDTH - 1);
    last_row = row == RW'(IMG_HEIGHT - 1);
    valid = done_i && state == STREAM && col >= CW'(4);
  end
  // Rightmost column is the oldest buffered line on top down to the live pixel.
  always_comb begin
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        nxt[i][j] = j < 4 ? win[i][j+1] : (i == 4 ? pixel_i : lb[3-i][col]);
  end
  // Buffer and window contents are don't-care after reset; the counters gate output.
  always_ff @(posedge clk) begin
    if (done_i) begin
      win <= nxt;
      lb[0][col] <= pixel_i;
      for (int k = 1; k < 4; k++) lb[k][col] <= lb[k-1][col];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      done_o <= 1'b0;
      frame_done_o <= 1'b0;
      for (int k = 0; k < 25; k++) s[k] <= '0;
    end else begin
      done_o <= valid;
      frame_done_o <= valid && last_col && last_row;
      if (done_i) begin
        col <= last_col ? '0 : col + CW'(1);
        row <= last_col ? (last_row ? '0 : row + RW'(1)) : row;
      end
      if (valid)
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++) s[i*5+j] <= nxt[i][j];
    end
  end
  assign S1 = s[0];
  assign S2 = s[1];
  assign S3 = s[2];
  assign S4 = s[3];
  assign S5 = s[4];
  assign S6 = s[5];
  assign S7 = s[6];
  assign S8 = s[7];
  assign S9 = s[8];
  assign S10 = s[9];
  assign S11 = s[10];
  assign S12 = s[11];
  assign S13 = s[12];
  assign S14 = s[13];
  assign S15 = s[14];
  assign S16 = s[15];
  assign S17 = s[16];
  assign S18 = s[17];
  assign S19 = s[18];
  assign S20 = s[19];
  assign S21 = s[20];
  assign S22 = s[21];
  assign S23 = s[22];
  assign S24 = s[23];
  assign S25 = s[24];
endmodule

// File: tb/tb_median_filter_5x5_window.sv
// tb_median_filter_5x5_window: directed and random frames on a 6x6 image,
// checked against a raster-indexed image model.
module tb_median_filter_5x5_window;
  localparam int W = 6;
  localparam int H = 6;
  logic clk = 1'b0;
  logic rst, done_i, done_o, frame_done_o;
  logic [7:0] pixel_i;
  logic [7:0] s [25];
  logic [7:0] img [W*H];
  logic [7:0] exp_s [25];
  int idx = 0, vectors = 0, fails = 0, ndone = 0, nfd = 0, base_d, base_f;

  always #5 clk = ~clk;

  median_filter_5x5_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .pixel_i(pixel_i),
    .S1(s[0]), .S2(s[1]), .S3(s[2]), .S4(s[3]), .S5(s[4]),
    .S6(s[5]), .S7(s[6]), .S8(s[7]), .S9(s[8]), .S10(s[9]),
    .S11(s[10]), .S12(s[11]), .S13(s[12]), .S14(s[13]), .S15(s[14]),
    .S16(s[15]), .S17(s[16]), .S18(s[17]), .S19(s[18]), .S20(s[19]),
    .S21(s[20]), .S22(s[21]), .S23(s[22]), .S24(s[23]), .S25(s[24]),
    .done_o(done_o), .frame_done_o(frame_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    chk("done_o", {31'd0, done_o}, 0);
    chk("frame_done_o", {31'd0, frame_done_o}, 0);
    for (int k = 0; k < 25; k++) chk($sformatf("S%0d", k + 1), s[k], exp_s[k]);
  endtask

  task automatic step(input bit en, input logic [7:0] px);
    bit ed, ef;
    int r, c;
    done_i = en;
    pixel_i = en ? px : 8'($urandom);
    @(posedge clk);
    #1;
    ed = 0;
    ef = 0;
    if (en) begin
      img[idx] = px;
      r = idx / W;
      c = idx % W;
      if (r >= 4 && c >= 4) begin
        ed = 1;
        ef = idx == W * H - 1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++) exp_s[i*5+j] = img[(r-4+i)*W + c-4+j];
      end
      idx = (idx + 1) % (W * H);
    end
    chk("done_o", {31'd0, done_o}, {31'd0, ed});
    chk("frame_done_o", {31'd0, frame_done_o}, {31'd0, ef});
    for (int k = 0; k < 25; k++) chk($sformatf("S%0d", k + 1), s[k], exp_s[k]);
    ndone += int'(done_o);
    nfd += int'(frame_done_o);
  endtask

  task automatic gappy(input logic [7:0] px);
    if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) step(0, 8'h00);
    step(1, px);
  endtask

  initial begin
    rst = 1'b0;
    done_i = 1'($urandom);
    pixel_i = 8'($urandom);
    for (int k = 0; k < 25; k++) exp_s[k] = 8'd0;
    #1 rst = 1'b1;
    #1 chk_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    done_i = 1'b0;
    rst = 1'b0;

    base_d = ndone;
    base_f = nfd;
    for (int p = 0; p < W * H; p++) begin
      step(1, 8'(p));
      if (p == 28) begin
        chk("first_S1", s[0], 8'd0);
        chk("first_S5", s[4], 8'd4);
        chk("first_S13", s[12], 8'd14);
        chk("first_S21", s[20], 8'd24);
        chk("first_S25", s[24], 8'd28);
      end
      if (p == 35) begin
        chk("last_S1", s[0], 8'd7);
        chk("last_S25", s[24], 8'd35);
      end
    end
    chk("cont_done_count", ndone - base_d, 4);
    chk("cont_fd_count", nfd - base_f, 1);

    base_d = ndone;
    for (int p = 0; p < W * H; p++) gappy(8'(p));
    step(0, 8'h00);
    chk("gap_done_count", ndone - base_d, 4);

    base_d = ndone;
    base_f = nfd;
    for (int p = 0; p < W * H; p++) step(1, 8'(p));
    for (int p = 0; p < W * H; p++) begin
      step(1, 8'(100 + p));
      if (p == 28) begin
        chk("f2_S1", s[0], 8'd100);
        chk("f2_S13", s[12], 8'd114);
        chk("f2_S25", s[24], 8'd128);
      end
    end
    chk("b2b_done_count", ndone - base_d, 8);
    chk("b2b_fd_count", nfd - base_f, 2);

    for (int p = 0; p < 20; p++) step(1, 8'($urandom));
    rst = 1'b1;
    idx = 0;
    for (int k = 0; k < 25; k++) exp_s[k] = 8'd0;
    #1 chk_all();
    done_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    base_d = ndone;
    for (int p = 0; p < W * H; p++) begin
      step(1, 8'(p));
      if (p == 35) chk("rst_last_S1", s[0], 8'd7);
    end
    chk("rst_done_count", ndone - base_d, 4);

    for (int p = 0; p < W * H; p++) begin
      step(1, 8'd255);
      if (done_o) for (int k = 0; k < 25; k++) chk("sat_S", s[k], 8'd255);
    end

    base_d = ndone;
    base_f = nfd;
    for (int p = 0; p < 2 * W * H; p++) gappy(8'($urandom));
    chk("rand_done_count", ndone - base_d, 8);
    chk("rand_fd_count", nfd - base_f, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
